// File: rtl/arb_req_pkg.sv
// Shared constants and types for the arbiter request generator.
// Default widths here match the top-level parameter defaults.
package arb_req_pkg;

   localparam int unsigned N_CLIENTS        = 2;
   localparam int unsigned DEF_MAX_PENDING  = 7;
   localparam int unsigned DEF_WAIT_W       = 8;
   localparam int unsigned DEF_STARVE_LIMIT = 4;
   localparam int unsigned PEND_W           = $clog2(DEF_MAX_PENDING + 1);

   typedef logic [PEND_W-1:0]     pend_t;
   typedef logic [DEF_WAIT_W-1:0] wait_t;

endpackage

// File: rtl/arb_request_slot.sv
// One client's job counter, grant-wait timer and sticky starvation flag.
// request/job_ready come from registered state only, so no path runs back from the arbiter.
module arb_request_slot #(
   parameter int unsigned MAX_PENDING  = 7,
   parameter int unsigned WAIT_W       = 8,
   parameter int unsigned STARVE_LIMIT = 4,
   localparam int unsigned PW          = $clog2(MAX_PENDING + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              job_valid,
   input  logic              grant_ok,
   output logic              job_ready,
   output logic              request,
   output logic [PW-1:0]     pending,
   output logic [WAIT_W-1:0] wait_cnt,
   output logic              starved
);

   localparam logic [PW-1:0]     PEND_MAX  = PW'(MAX_PENDING);
   localparam logic [WAIT_W-1:0] STARVE_TH = WAIT_W'(STARVE_LIMIT);

   logic [PW-1:0]     pend_q, pend_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              starved_q, starved_d;
   logic              acc;

   assign job_ready = (pend_q < PEND_MAX);
   assign request   = (pend_q != '0);
   assign acc       = job_valid && job_ready;

   always_comb begin
      pend_d = pend_q;
      if (acc && !grant_ok) begin
         pend_d = pend_q + PW'(1);
      end else if (!acc && grant_ok) begin
         pend_d = pend_q - PW'(1);
      end

      // Any cycle that is not an ungranted request restarts the measurement.
      wait_d = '0;
      if (request && !grant_ok) begin
         wait_d = (wait_q == '1) ? wait_q : wait_q + WAIT_W'(1);
      end

      starved_d = starved_q || (wait_d >= STARVE_TH);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pend_q    <= '0;
         wait_q    <= '0;
         starved_q <= 1'b0;
      end else begin
         pend_q    <= pend_d;
         wait_q    <= wait_d;
         starved_q <= starved_d;
      end
   end

   assign pending  = pend_q;
   assign wait_cnt = wait_q;
   assign starved  = starved_q;

endmodule

// File: rtl/arb_request_generator.sv
// Turns two clients' job submissions into arbiter requests and retires jobs on grants.
// Holds the shared grant-legality check; per-client state lives in arb_request_slot.
module arb_request_generator
   import arb_req_pkg::*;
#(
   parameter int unsigned MAX_PENDING  = DEF_MAX_PENDING,
   parameter int unsigned WAIT_W       = DEF_WAIT_W,
   parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
   localparam int unsigned PW          = $clog2(MAX_PENDING + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_CLIENTS-1:0] job_valid,
   output logic [N_CLIENTS-1:0] job_ready,
   output logic [N_CLIENTS-1:0] requests,
   input  logic [N_CLIENTS-1:0] grants,
   output logic [PW-1:0]        pending_0,
   output logic [PW-1:0]        pending_1,
   output logic [WAIT_W-1:0]    wait_0,
   output logic [WAIT_W-1:0]    wait_1,
   output logic [N_CLIENTS-1:0] starved,
   output logic                 proto_err
);

   logic [N_CLIENTS-1:0] g_ok;
   logic                 grant_both;
   logic                 proto_err_q, proto_err_d;

   // A double grant is discarded entirely; a lone grant counts only if requested.
   assign grant_both = (grants == {N_CLIENTS{1'b1}});
   assign g_ok       = grants & requests & {N_CLIENTS{!grant_both}};

   always_comb begin
      proto_err_d = proto_err_q || grant_both || (|(grants & ~requests));
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         proto_err_q <= 1'b0;
      end else begin
         proto_err_q <= proto_err_d;
      end
   end

   assign proto_err = proto_err_q;

   arb_request_slot #(
      .MAX_PENDING  (MAX_PENDING),
      .WAIT_W       (WAIT_W),
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_slot_0 (
      .clk       (clk),
      .rst       (rst),
      .job_valid (job_valid[0]),
      .grant_ok  (g_ok[0]),
      .job_ready (job_ready[0]),
      .request   (requests[0]),
      .pending   (pending_0),
      .wait_cnt  (wait_0),
      .starved   (starved[0])
   );

   arb_request_slot #(
      .MAX_PENDING  (MAX_PENDING),
      .WAIT_W       (WAIT_W),
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_slot_1 (
      .clk       (clk),
      .rst       (rst),
      .job_valid (job_valid[1]),
      .grant_ok  (g_ok[1]),
      .job_ready (job_ready[1]),
      .request   (requests[1]),
      .pending   (pending_1),
      .wait_cnt  (wait_1),
      .starved   (starved[1])
   );

endmodule
